// File: rtl/mips_avalon_arbiter.sv
// ============================================================================
// Module  : mips_avalon_arbiter
// Brief   : Two-master (I-fetch, D-access) to one-slave Avalon-MM arbiter.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_avalon_arbiter #(
  parameter int ROUND_ROBIN = 1
) (
  input  logic        clk,
  input  logic        reset,
  // instruction-fetch master
  input  logic [31:0] i_address,
  input  logic        i_read,
  output logic        i_waitrequest,
  output logic [31:0] i_readdata,
  // data-access master
  input  logic [31:0] d_address,
  input  logic        d_read,
  input  logic        d_write,
  input  logic [31:0] d_writedata,
  input  logic [3:0]  d_byteenable,
  output logic        d_waitrequest,
  output logic [31:0] d_readdata,
  // slave port
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [31:0] writedata,
  output logic [3:0]  byteenable,
  input  logic        waitrequest,
  input  logic [31:0] readdata,
  // status
  output logic [1:0]  grant
);

  // Encodings double as the grant status value.
  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_OWN_I = 2'b01,
    S_OWN_D = 2'b10
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_d;   // 1: D held the most recent grant
  logic   w_i_req;
  logic   w_d_req;

  assign w_i_req = i_read;
  assign w_d_req = d_read | d_write;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_last_d <= 1'b1;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_next == S_OWN_I) r_last_d <= 1'b0;
      else if (r_state == S_IDLE && w_next == S_OWN_D) r_last_d <= 1'b1;
    end
  end

  always_comb begin
    w_next        = r_state;
    address       = 32'h0;
    read          = 1'b0;
    write         = 1'b0;
    writedata     = 32'h0;
    byteenable    = 4'h0;
    i_waitrequest = 1'b1;
    i_readdata    = 32'h0;
    d_waitrequest = 1'b1;
    d_readdata    = 32'h0;
    grant         = r_state;

    case (r_state)
      S_IDLE: begin
        if (w_i_req && w_d_req)
          w_next = (ROUND_ROBIN != 0 && r_last_d) ? S_OWN_I : S_OWN_D;
        else if (w_i_req)
          w_next = S_OWN_I;
        else if (w_d_req)
          w_next = S_OWN_D;
      end
      S_OWN_I: begin
        address       = i_address;
        read          = i_read;
        byteenable    = 4'hF;
        i_waitrequest = waitrequest;
        i_readdata    = readdata;
        // Dropped request is an abort; otherwise leave on the completing cycle.
        if (!w_i_req || !waitrequest) w_next = S_IDLE;
      end
      S_OWN_D: begin
        address       = d_address;
        write         = d_write;
        read          = d_read & ~d_write;   // simultaneous read+write: write wins
        writedata     = d_writedata;
        byteenable    = d_byteenable;
        d_waitrequest = waitrequest;
        d_readdata    = readdata;
        if (!w_d_req || !waitrequest) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_mips_avalon_arbiter.sv
// ============================================================================
// Module  : tb_mips_avalon_arbiter
// Brief   : Scoreboard bench for mips_avalon_arbiter, round-robin and fixed-priority.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_avalon_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] i_address = '0, d_address = '0, d_writedata = '0, readdata = '0;
  logic        i_read = 1'b0, d_read = 1'b0, d_write = 1'b0, waitrequest = 1'b0;
  logic [3:0]  d_byteenable = '0;

  logic        rr_i_wr, rr_d_wr, rr_read, rr_write;
  logic [31:0] rr_i_rd, rr_d_rd, rr_address, rr_writedata;
  logic [3:0]  rr_be;
  logic [1:0]  rr_grant;
  logic        fp_i_wr, fp_d_wr, fp_read, fp_write;
  logic [31:0] fp_i_rd, fp_d_rd, fp_address, fp_writedata;
  logic [3:0]  fp_be;
  logic [1:0]  fp_grant;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] rd_q[$];
  logic [1:0]  g_rr_q[$];
  logic [1:0]  g_fp_q[$];

  always #5 clk = ~clk;

  mips_avalon_arbiter #(.ROUND_ROBIN(1)) u_rr (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(rr_i_wr), .i_readdata(rr_i_rd),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(rr_d_wr), .d_readdata(rr_d_rd),
    .address(rr_address), .read(rr_read), .write(rr_write), .writedata(rr_writedata),
    .byteenable(rr_be), .waitrequest(waitrequest), .readdata(readdata), .grant(rr_grant)
  );

  mips_avalon_arbiter #(.ROUND_ROBIN(0)) u_fp (
    .clk(clk), .reset(reset),
    .i_address(i_address), .i_read(i_read), .i_waitrequest(fp_i_wr), .i_readdata(fp_i_rd),
    .d_address(d_address), .d_read(d_read), .d_write(d_write), .d_writedata(d_writedata),
    .d_byteenable(d_byteenable), .d_waitrequest(fp_d_wr), .d_readdata(fp_d_rd),
    .address(fp_address), .read(fp_read), .write(fp_write), .writedata(fp_writedata),
    .byteenable(fp_be), .waitrequest(waitrequest), .readdata(readdata), .grant(fp_grant)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, act, exp);
    end
  endtask

  task automatic sb_pop(input string tag, input logic [31:0] act);
    if (rd_q.size() == 0) check({tag, "_sbempty"}, 32'(rd_q.size()), 32'd1);
    else check(tag, act, rd_q.pop_front());
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    i_address = '0; i_read = 1'b0;
    d_address = '0; d_read = 1'b0; d_write = 1'b0; d_writedata = '0; d_byteenable = '0;
    waitrequest = 1'b0; readdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    check("rst_grant", 32'(rr_grant), 32'd0);
    check("rst_iwait", 32'(rr_i_wr), 32'd1);
    check("rst_dwait", 32'(rr_d_wr), 32'd1);
    check("rst_addr", rr_address, 32'h0);
    check("rst_be", 32'(rr_be), 32'd0);
    tick();
    reset = 1'b0;

    // single fetch
    i_read = 1'b1; i_address = 32'hBFC00000; waitrequest = 1'b0; readdata = 32'h24020005;
    rd_q.push_back(32'h24020005);
    #1;
    check("t1_idle_grant", 32'(rr_grant), 32'd0);
    check("t1_idle_iwait", 32'(rr_i_wr), 32'd1);
    tick();
    check("t1_grant", 32'(rr_grant), 32'd1);
    check("t1_addr", rr_address, 32'hBFC00000);
    check("t1_read", 32'(rr_read), 32'd1);
    check("t1_iwait", 32'(rr_i_wr), 32'd0);
    if (i_read && !rr_i_wr) sb_pop("t1_rdata", rr_i_rd);
    i_read = 1'b0;
    tick();
    check("t1_after", 32'(rr_grant), 32'd0);

    // alternating grants under constant contention
    do_reset();
    i_read = 1'b1; d_read = 1'b1; d_address = 32'h2000; waitrequest = 1'b0;
    for (int k = 0; k < 2; k++) begin
      g_rr_q.push_back(2'b01); g_rr_q.push_back(2'b00);
      g_rr_q.push_back(2'b10); g_rr_q.push_back(2'b00);
      g_fp_q.push_back(2'b10); g_fp_q.push_back(2'b00);
      g_fp_q.push_back(2'b10); g_fp_q.push_back(2'b00);
    end
    while (g_rr_q.size() > 0) begin
      tick();
      check("t2_rr_grant", 32'(rr_grant), 32'(g_rr_q.pop_front()));
      check("t2_fp_grant", 32'(fp_grant), 32'(g_fp_q.pop_front()));
    end

    // fixed priority with slave wait states
    do_reset();
    i_read = 1'b1; d_read = 1'b1; d_address = 32'h3000;
    waitrequest = 1'b1; readdata = 32'hCAFEF00D;
    rd_q.push_back(32'hCAFEF00D);
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_grant", 32'(fp_grant), 32'd2);
      check("t3_iwait", 32'(fp_i_wr), 32'd1);
      check("t3_dwait", 32'(fp_d_wr), 32'd1);
    end
    waitrequest = 1'b0;
    #1;
    check("t3_dwait_done", 32'(fp_d_wr), 32'd0);
    if (d_read && !fp_d_wr) sb_pop("t3_rdata", fp_d_rd);
    check("t3_iwait_done", 32'(fp_i_wr), 32'd1);
    i_read = 1'b0; d_read = 1'b0;
    tick();
    check("t3_idle", 32'(fp_grant), 32'd0);

    // byte store
    do_reset();
    d_write = 1'b1; d_address = 32'h00001000; d_byteenable = 4'b0100;
    d_writedata = 32'h00AB0000; readdata = 32'hDEADBEEF; waitrequest = 1'b0;
    tick();
    check("t4_grant", 32'(rr_grant), 32'd2);
    check("t4_addr", rr_address, 32'h00001000);
    check("t4_write", 32'(rr_write), 32'd1);
    check("t4_read", 32'(rr_read), 32'd0);
    check("t4_wdata", rr_writedata, 32'h00AB0000);
    check("t4_be", 32'(rr_be), 32'b0100);
    check("t4_iwait", 32'(rr_i_wr), 32'd1);
    check("t4_irdata", rr_i_rd, 32'h0);
    d_read = 1'b1;
    tick();
    tick();
    check("t4_rw_write", 32'(rr_write), 32'd1);
    check("t4_rw_read", 32'(rr_read), 32'd0);

    // asynchronous reset in the middle of a transfer
    do_reset();
    d_write = 1'b1; d_byteenable = 4'hF; waitrequest = 1'b1;
    tick();
    check("t5_write", 32'(rr_write), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("t5_rst_write", 32'(rr_write), 32'd0);
    check("t5_rst_be", 32'(rr_be), 32'd0);
    check("t5_rst_grant", 32'(rr_grant), 32'd0);
    check("t5_rst_dwait", 32'(rr_d_wr), 32'd1);
    reset = 1'b0;
    d_write = 1'b0; i_read = 1'b1; i_address = 32'h400; waitrequest = 1'b0;
    tick();
    check("t5_igrant", 32'(rr_grant), 32'd1);
    check("t5_iaddr", rr_address, 32'h400);
    i_read = 1'b0;
    tick();

    // abort by the owning master, then pending D granted
    do_reset();
    i_read = 1'b1; i_address = 32'hBFC00010; waitrequest = 1'b1;
    tick();
    check("t6_read", 32'(rr_read), 32'd1);
    i_read = 1'b0; d_read = 1'b1; d_address = 32'h2000;
    #1;
    check("t6_abort_read", 32'(rr_read), 32'd0);
    check("t6_abort_grant", 32'(rr_grant), 32'd1);
    tick();
    check("t6_idle", 32'(rr_grant), 32'd0);
    tick();
    check("t6_dgrant", 32'(rr_grant), 32'd2);
    check("t6_daddr", rr_address, 32'h2000);
    check("t6_dread", 32'(rr_read), 32'd1);
    clear_inputs();
    tick();

    check("sb_drained", 32'(rd_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
